fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch/decode sequencer: walks each instruction through
// IF/ID/EX/MEM/WB, maintains the PC and instruction register, and counts retirements.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [2:0] HALT_OPCODE = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [7:0] imem_data,
    input  logic       imem_ready,
    output logic [7:0] imem_addr,
    output logic [7:0] pc,
    output logic [7:0] instr,
    output logic [2:0] opcode,
    output logic [1:0] reg_a,
    output logic [2:0] immediate,
    output logic [4:0] jump_addr_short,
    output logic       if_stage,
    output logic       id_stage,
    output logic       ex_stage,
    output logic       mem_stage,
    output logic       wb_stage,
    output logic       halted,
    output logic [7:0] retired
);

    localparam logic [2:0] OP_LW   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       retire;
    logic [5:0] strobes;

    // Strobe order: {if, id, ex, mem, wb, halted}
    function automatic logic [5:0] decode_strobes(input state_t s);
        case (s)
            S_IF:    decode_strobes = 6'b100000;
            S_ID:    decode_strobes = 6'b010000;
            S_EX:    decode_strobes = 6'b001000;
            S_MEM:   decode_strobes = 6'b000100;
            S_WB:    decode_strobes = 6'b000010;
            S_HALT:  decode_strobes = 6'b000001;
            default: decode_strobes = 6'b100000;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        if (!stall) begin
            case (state)
                S_IF: begin
                    if (imem_ready) state_nxt = S_ID;
                end
                S_ID: begin
                    // Jump is tested first so it wins if HALT_OPCODE is ever set to 010
                    if (opcode == OP_JUMP) begin
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end else if (opcode == HALT_OPCODE) begin
                        retire    = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_EX;
                    end
                end
                S_EX: begin
                    if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEM;
                    else                                    state_nxt = S_WB;
                end
                S_MEM: begin
                    if (opcode == OP_SW) begin
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
                S_WB: begin
                    retire    = 1'b1;
                    state_nxt = S_IF;
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IF;
            pc      <= RESET_PC;
            instr   <= 8'h00;
            retired <= 8'h00;
            strobes <= 6'b100000;
        end else if (!stall) begin
            state   <= state_nxt;
            strobes <= decode_strobes(state_nxt);
            if (state == S_IF && imem_ready) begin
                instr <= imem_data;
                pc    <= pc + 8'd1;
            end
            if (state == S_ID && opcode == OP_JUMP) begin
                pc <= {3'b000, jump_addr_short};
            end
            if (retire) begin
                retired <= retired + 8'd1;
            end
        end
    end

    assign imem_addr       = pc;
    assign opcode          = instr[7:5];
    assign reg_a           = instr[4:3];
    assign immediate       = instr[2:0];
    assign jump_addr_short = instr[4:0];

    assign {if_stage, id_stage, ex_stage, mem_stage, wb_stage, halted} = strobes;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table walking addi/lw/sw/jump/halt
// with ready/stall holds, then hand sequences for reset-in-MEM and PC/retired wrap.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       stall;
    logic [7:0] imem_data;
    logic       imem_ready;
    logic [7:0] imem_addr;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [2:0] opcode;
    logic [1:0] reg_a;
    logic [2:0] immediate;
    logic [4:0] jump_addr_short;
    logic       if_stage, id_stage, ex_stage, mem_stage, wb_stage, halted;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] ST_IF  = 6'b100000;
    localparam logic [5:0] ST_ID  = 6'b010000;
    localparam logic [5:0] ST_EX  = 6'b001000;
    localparam logic [5:0] ST_MEM = 6'b000100;
    localparam logic [5:0] ST_WB  = 6'b000010;
    localparam logic [5:0] ST_HT  = 6'b000001;

    typedef struct {
        logic       rst;
        logic       stl;
        logic       rdy;
        logic [7:0] data;
        logic [5:0] strb;
        logic [7:0] epc;
        logic [7:0] eins;
        logic [7:0] eret;
    } vec_t;

    vec_t vq[$];

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .imem_data       (imem_data),
        .imem_ready      (imem_ready),
        .imem_addr       (imem_addr),
        .pc              (pc),
        .instr           (instr),
        .opcode          (opcode),
        .reg_a           (reg_a),
        .immediate       (immediate),
        .jump_addr_short (jump_addr_short),
        .if_stage        (if_stage),
        .id_stage        (id_stage),
        .ex_stage        (ex_stage),
        .mem_stage       (mem_stage),
        .wb_stage        (wb_stage),
        .halted          (halted),
        .retired         (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [7:0] d);
        reset      = r;
        stall      = s;
        imem_ready = rd;
        imem_data  = d;
    endtask

    function automatic logic [5:0] strobes_now();
        return {if_stage, id_stage, ex_stage, mem_stage, wb_stage, halted};
    endfunction

    task automatic add(input logic r, input logic s, input logic rd, input logic [7:0] d,
                       input logic [5:0] st, input logic [7:0] p, input logic [7:0] i,
                       input logic [7:0] rt);
        vec_t v;
        v.rst = r; v.stl = s; v.rdy = rd; v.data = d;
        v.strb = st; v.epc = p; v.eins = i; v.eret = rt;
        vq.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // inputs applied before the edge; expectations observed after it
        add(1, 0, 0, 8'h00, ST_IF,  8'h00, 8'h00, 8'd0); // reset
        add(0, 0, 1, 8'h85, ST_ID,  8'h01, 8'h85, 8'd0); // addi imm 5
        add(0, 0, 1, 8'h00, ST_EX,  8'h01, 8'h85, 8'd0);
        add(0, 0, 1, 8'h00, ST_WB,  8'h01, 8'h85, 8'd0);
        add(0, 0, 1, 8'h00, ST_IF,  8'h01, 8'h85, 8'd1);
        add(0, 0, 1, 8'h1B, ST_ID,  8'h02, 8'h1B, 8'd1); // lw
        add(0, 0, 1, 8'h00, ST_EX,  8'h02, 8'h1B, 8'd1);
        add(0, 0, 1, 8'h00, ST_MEM, 8'h02, 8'h1B, 8'd1);
        add(0, 0, 1, 8'h00, ST_WB,  8'h02, 8'h1B, 8'd1);
        add(0, 0, 1, 8'h00, ST_IF,  8'h02, 8'h1B, 8'd2);
        add(0, 0, 1, 8'h3B, ST_ID,  8'h03, 8'h3B, 8'd2); // sw
        add(0, 0, 1, 8'h00, ST_EX,  8'h03, 8'h3B, 8'd2);
        add(0, 0, 1, 8'h00, ST_MEM, 8'h03, 8'h3B, 8'd2);
        add(0, 0, 1, 8'h00, ST_IF,  8'h03, 8'h3B, 8'd3);
        add(0, 0, 0, 8'h5C, ST_IF,  8'h03, 8'h3B, 8'd3); // not ready x3
        add(0, 0, 0, 8'h5C, ST_IF,  8'h03, 8'h3B, 8'd3);
        add(0, 0, 0, 8'h5C, ST_IF,  8'h03, 8'h3B, 8'd3);
        add(0, 1, 1, 8'h5C, ST_IF,  8'h03, 8'h3B, 8'd3); // stall beats ready
        add(0, 0, 1, 8'h5C, ST_ID,  8'h04, 8'h5C, 8'd3); // jump 1C
        add(0, 0, 1, 8'h00, ST_IF,  8'h1C, 8'h5C, 8'd4);
        add(0, 0, 1, 8'h85, ST_ID,  8'h1D, 8'h85, 8'd4);
        add(0, 0, 1, 8'h00, ST_EX,  8'h1D, 8'h85, 8'd4);
        add(0, 1, 1, 8'h00, ST_EX,  8'h1D, 8'h85, 8'd4); // stall in EX x2
        add(0, 1, 1, 8'h00, ST_EX,  8'h1D, 8'h85, 8'd4);
        add(0, 0, 1, 8'h00, ST_WB,  8'h1D, 8'h85, 8'd4);
        add(0, 0, 1, 8'h00, ST_IF,  8'h1D, 8'h85, 8'd5);
        add(0, 0, 1, 8'hE0, ST_ID,  8'h1E, 8'hE0, 8'd5); // halt
        add(0, 0, 1, 8'h00, ST_HT,  8'h1E, 8'hE0, 8'd6);
        add(0, 1, 1, 8'h85, ST_HT,  8'h1E, 8'hE0, 8'd6);
        add(0, 0, 1, 8'h85, ST_HT,  8'h1E, 8'hE0, 8'd6);
        add(1, 1, 1, 8'h85, ST_IF,  8'h00, 8'h00, 8'd0); // reset beats stall in HALT

        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].stl, vq[k].rdy, vq[k].data);
            step();
            chk($sformatf("v%0d_strobes", k), 32'(strobes_now()), 32'(vq[k].strb));
            chk($sformatf("v%0d_pc", k), 32'(pc), 32'(vq[k].epc));
            chk($sformatf("v%0d_addr", k), 32'(imem_addr), 32'(vq[k].epc));
            chk($sformatf("v%0d_instr", k), 32'(instr), 32'(vq[k].eins));
            chk($sformatf("v%0d_retired", k), 32'(retired), 32'(vq[k].eret));
        end

        // Field decode of a known instruction
        drive(0, 0, 1, 8'h85);
        step();
        chk("dec_opcode", 32'(opcode), 32'h4);
        chk("dec_reg_a", 32'(reg_a), 32'h0);
        chk("dec_imm", 32'(immediate), 32'h5);
        chk("dec_jshort", 32'(jump_addr_short), 32'h05);
        step(); step(); step();
        chk("addi_done_ret", 32'(retired), 32'd1);

        // Reset arriving while a lw sits in MEM
        drive(0, 0, 1, 8'h1B);
        step(); step(); step();
        chk("mid_lw_mem", 32'(strobes_now()), 32'(ST_MEM));
        drive(1, 0, 1, 8'h1B);
        step();
        chk("rst_mem_strobes", 32'(strobes_now()), 32'(ST_IF));
        chk("rst_mem_pc", 32'(pc), 32'h00);
        chk("rst_mem_ret", 32'(retired), 32'h00);
        chk("rst_mem_instr", 32'(instr), 32'h00);

        // 255 addi instructions bring pc and retired to FF; one more wraps both
        drive(0, 0, 1, 8'h85);
        for (int n = 0; n < 255; n++) begin
            step(); step(); step(); step();
        end
        chk("pre_wrap_pc", 32'(pc), 32'hFF);
        chk("pre_wrap_ret", 32'(retired), 32'hFF);
        chk("pre_wrap_if", 32'(strobes_now()), 32'(ST_IF));
        step();
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("wrap_id", 32'(strobes_now()), 32'(ST_ID));
        step(); step(); step();
        chk("wrap_ret", 32'(retired), 32'h00);
        chk("wrap_if", 32'(strobes_now()), 32'(ST_IF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
